// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state type, ALU op codes, flag indices and op-class helpers
// for alu_op_sequencer and its flag register.
package alu_seq_pkg;

   localparam int unsigned SEQ_XLEN = 32;
   localparam int unsigned SEQ_OPW  = 4;
   localparam int unsigned NFLAG    = 4;

   // Bit positions inside an NZCV nibble
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Arithmetic and compare op codes (same encoding as the ALU)
   localparam logic [SEQ_OPW-1:0] OP_SUB = 4'b0010;
   localparam logic [SEQ_OPW-1:0] OP_RSB = 4'b0011;
   localparam logic [SEQ_OPW-1:0] OP_ADD = 4'b0100;
   localparam logic [SEQ_OPW-1:0] OP_ADC = 4'b0101;
   localparam logic [SEQ_OPW-1:0] OP_SBC = 4'b0110;
   localparam logic [SEQ_OPW-1:0] OP_RSC = 4'b0111;
   localparam logic [SEQ_OPW-1:0] OP_TST = 4'b1000;
   localparam logic [SEQ_OPW-1:0] OP_TEQ = 4'b1001;
   localparam logic [SEQ_OPW-1:0] OP_CMP = 4'b1010;
   localparam logic [SEQ_OPW-1:0] OP_CMN = 4'b1011;

   // Op used for the high word of a wide operation (carry-chained form)
   function automatic logic [SEQ_OPW-1:0] hi_op(input logic [SEQ_OPW-1:0] op);
      logic [SEQ_OPW-1:0] r;
      case (op)
         OP_ADD, OP_ADC, OP_CMN: r = OP_ADC;
         OP_SUB, OP_SBC, OP_CMP: r = OP_SBC;
         OP_RSB, OP_RSC:         r = OP_RSC;
         default:                r = op;
      endcase
      return r;
   endfunction

   function automatic logic is_add_class(input logic [SEQ_OPW-1:0] op);
      return (op == OP_ADD) || (op == OP_ADC) || (op == OP_CMN);
   endfunction

   function automatic logic is_sub_class(input logic [SEQ_OPW-1:0] op);
      return (op == OP_SUB) || (op == OP_RSB) || (op == OP_SBC) ||
             (op == OP_RSC) || (op == OP_CMP);
   endfunction

   // Ops whose LO pass consumes the architectural carry
   function automatic logic uses_carry_lo(input logic [SEQ_OPW-1:0] op);
      return (op == OP_ADC) || (op == OP_SBC) || (op == OP_RSC);
   endfunction

   // Compare/test ops always commit their flags
   function automatic logic is_cmp_test(input logic [SEQ_OPW-1:0] op);
      return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// alu_flag_reg: architectural NZCV register plus the per-op response flags.
// Merges Z across the two passes of a wide op and commits on enable.
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   i_lo_done        end of the LO pass of a wide op (capture Z_lo)
//   i_final          end of the last pass of the op
//   i_wide           op is 64-bit
//   i_commit         write the merged flags into the architectural register
//   i_alu_flags      NZCV from the ALU for the current pass
//   o_rsp_flags      flags computed by the last op
//   o_nzcv           architectural flag register
module alu_flag_reg
   import alu_seq_pkg::*;
#(
   parameter logic [NFLAG-1:0] FLAGS_RST = 4'b0000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_lo_done,
   input  logic             i_final,
   input  logic             i_wide,
   input  logic             i_commit,
   input  logic [NFLAG-1:0] i_alu_flags,
   output logic [NFLAG-1:0] o_rsp_flags,
   output logic [NFLAG-1:0] o_nzcv
);

   logic             r_z_lo;
   logic [NFLAG-1:0] r_rsp_flags;
   logic [NFLAG-1:0] r_nzcv;
   logic             w_z;
   logic [NFLAG-1:0] w_merged;

   // Wide result is zero only if both halves are zero; N/C/V come from the high pass
   always_comb begin
      w_z      = i_wide ? (r_z_lo & i_alu_flags[FLAG_Z]) : i_alu_flags[FLAG_Z];
      w_merged = {i_alu_flags[FLAG_N], w_z, i_alu_flags[FLAG_C], i_alu_flags[FLAG_V]};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_z_lo      <= 1'b0;
         r_rsp_flags <= '0;
         r_nzcv      <= FLAGS_RST;
      end else begin
         if (i_lo_done) r_z_lo <= i_alu_flags[FLAG_Z];
         if (i_final) begin
            r_rsp_flags <= w_merged;
            if (i_commit) r_nzcv <= w_merged;
         end
      end
   end

   assign o_rsp_flags = r_rsp_flags;
   assign o_nzcv      = r_nzcv;

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller in front of a 32-bit ALU.
// Narrow ops take one ALU pass, wide (64-bit) ops take a LO pass then a
// carry-chained HI pass. Owns NZCV and drives the ALU CarryIn from it.
// Optional macro ALU_OP_SEQUENCER_B2B_EN: accept a new op in RESP while the
// response is consumed, skipping the IDLE cycle.
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   req_valid/req_ready              request handshake
//   req_op/req_wide/req_setflags     op code, 64-bit select, flag update
//   req_a/req_b                      64-bit operands (upper half unused when narrow)
//   alu_src_a/b, alu_control         ALU inputs (zero outside LO/HI)
//   alu_carry_in                     ALU carry input
//   alu_result/alu_flags             ALU outputs
//   rsp_valid/rsp_ready              response handshake
//   rsp_result/rsp_flags             64-bit result and flags of the op
//   nzcv                             architectural flag register
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned     XLEN      = SEQ_XLEN,
   parameter int unsigned     OPW       = SEQ_OPW,
   parameter logic [NFLAG-1:0] FLAGS_RST = 4'b0000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OPW-1:0]    req_op,
   input  logic              req_wide,
   input  logic              req_setflags,
   input  logic [2*XLEN-1:0] req_a,
   input  logic [2*XLEN-1:0] req_b,
   output logic [XLEN-1:0]   alu_src_a,
   output logic [XLEN-1:0]   alu_src_b,
   output logic [OPW-1:0]    alu_control,
   output logic              alu_carry_in,
   input  logic [XLEN-1:0]   alu_result,
   input  logic [NFLAG-1:0]  alu_flags,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [2*XLEN-1:0] rsp_result,
   output logic [NFLAG-1:0]  rsp_flags,
   output logic [NFLAG-1:0]  nzcv
);

   state_t              r_state, w_next;
   logic                r_req_ready;
   logic [OPW-1:0]      r_op;
   logic                r_wide, r_setflags;
   logic [XLEN-1:0]     r_a_hi, r_b_hi, r_res_lo;
   logic [XLEN-1:0]     r_alu_a, r_alu_b, w_alu_a, w_alu_b;
   logic [OPW-1:0]      r_alu_ctl, w_alu_ctl;
   logic                r_alu_cin, w_alu_cin;
   logic                r_rsp_valid;
   logic [2*XLEN-1:0]   r_rsp_result;
   logic                w_ready, w_accept, w_lo_done, w_final, w_commit;
   logic [NFLAG-1:0]    w_nzcv;

`ifdef ALU_OP_SEQUENCER_B2B_EN
   // Consuming the response frees the sequencer in the same cycle
   assign w_ready = r_req_ready | ((r_state == ST_RESP) & rsp_ready);
`else
   assign w_ready = r_req_ready;
`endif

   assign w_accept  = req_valid & w_ready;
   assign w_lo_done = (r_state == ST_LO) & r_wide;
   assign w_final   = ((r_state == ST_LO) & ~r_wide) | (r_state == ST_HI);
   assign w_commit  = r_setflags | is_cmp_test(r_op);

   // Next state and next ALU drive (registered so the ALU sees it during LO/HI)
   always_comb begin
      w_next    = r_state;
      w_alu_a   = '0;
      w_alu_b   = '0;
      w_alu_ctl = '0;
      w_alu_cin = 1'b0;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = ST_LO;
         ST_LO:   w_next = r_wide ? ST_HI : ST_RESP;
         ST_HI:   w_next = ST_RESP;
         ST_RESP: if (rsp_ready) w_next = w_accept ? ST_LO : ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
      if (w_accept) begin
         w_alu_a   = req_a[XLEN-1:0];
         w_alu_b   = req_b[XLEN-1:0];
         w_alu_ctl = req_op;
         w_alu_cin = uses_carry_lo(req_op) & w_nzcv[FLAG_C];
      end else if (w_next == ST_HI) begin
         w_alu_a   = r_a_hi;
         w_alu_b   = r_b_hi;
         w_alu_ctl = hi_op(r_op);
         // ALU C on subtract is a borrow, so the chained carry is inverted
         if (is_add_class(r_op))      w_alu_cin = alu_flags[FLAG_C];
         else if (is_sub_class(r_op)) w_alu_cin = ~alu_flags[FLAG_C];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_req_ready  <= 1'b0;
         r_op         <= '0;
         r_wide       <= 1'b0;
         r_setflags   <= 1'b0;
         r_a_hi       <= '0;
         r_b_hi       <= '0;
         r_res_lo     <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_ctl    <= '0;
         r_alu_cin    <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
      end else begin
         r_state     <= w_next;
         r_req_ready <= (w_next == ST_IDLE);
         r_rsp_valid <= (w_next == ST_RESP);
         r_alu_a     <= w_alu_a;
         r_alu_b     <= w_alu_b;
         r_alu_ctl   <= w_alu_ctl;
         r_alu_cin   <= w_alu_cin;
         if (w_accept) begin
            r_op       <= req_op;
            r_wide     <= req_wide;
            r_setflags <= req_setflags;
            r_a_hi     <= req_a[2*XLEN-1:XLEN];
            r_b_hi     <= req_b[2*XLEN-1:XLEN];
         end
         if (w_lo_done) r_res_lo <= alu_result;
         if (w_final)
            r_rsp_result <= r_wide ? {alu_result, r_res_lo} : {{XLEN{1'b0}}, alu_result};
      end
   end

   alu_flag_reg #(
      .FLAGS_RST (FLAGS_RST)
   ) u_flag_reg (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_lo_done   (w_lo_done),
      .i_final     (w_final),
      .i_wide      (r_wide),
      .i_commit    (w_commit),
      .i_alu_flags (alu_flags),
      .o_rsp_flags (rsp_flags),
      .o_nzcv      (w_nzcv)
   );

   assign req_ready    = w_ready;
   assign alu_src_a    = r_alu_a;
   assign alu_src_b    = r_alu_b;
   assign alu_control  = r_alu_ctl;
   assign alu_carry_in = r_alu_cin;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_result   = r_rsp_result;
   assign nzcv         = w_nzcv;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: bench for alu_op_sequencer. Models the parent's 32-bit
// ALU, and checks each response against whole-word (32/64-bit) arithmetic.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_wide, req_setflags;
   logic [3:0]  req_op;
   logic [63:0] req_a, req_b;
   logic [31:0] alu_src_a, alu_src_b, alu_result;
   logic [3:0]  alu_control, alu_flags;
   logic        alu_carry_in;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_result;
   logic [3:0]  rsp_flags, nzcv;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [3:0]  m_nzcv;
   logic [3:0]  tr_ctl [0:8];
   logic        tr_cin [0:8];
   logic [63:0] last_res;
   logic [3:0]  last_flags;
   logic [67:0] alu_w;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_wide(req_wide), .req_setflags(req_setflags), .req_a(req_a), .req_b(req_b),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .nzcv(nzcv)
   );

   // Op semantics at word width 32 or 64; returns {N,Z,C,V, result}.
   // Subtract-class C is a borrow; SBC/RSC subtract an extra 1 when c=0.
   function automatic logic [67:0] ref_op(input logic [3:0] op, input logic wide,
                                          input logic [63:0] a_i, input logic [63:0] b_i,
                                          input logic c);
      int          w, msb;
      logic [64:0] x, y, t, r;
      logic [63:0] mask, rr;
      logic        add, sub, cf, v;
      w    = wide ? 64 : 32;
      msb  = w - 1;
      mask = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      x    = {1'b0, a_i & mask};
      y    = {1'b0, b_i & mask};
      add  = 1'b0;
      sub  = 1'b0;
      if (op == 4'b0011 || op == 4'b0111) begin t = x; x = y; y = t; end
      case (op)
         4'b0000, 4'b1000: r = x & y;
         4'b0001, 4'b1001: r = x ^ y;
         4'b1100:          r = x | y;
         4'b1101:          r = y;
         4'b1110:          r = x & ~y;
         4'b1111:          r = ~y;
         4'b0100, 4'b1011: begin r = x + y; add = 1'b1; end
         4'b0101:          begin r = x + y + 65'(c); add = 1'b1; end
         4'b0010, 4'b0011, 4'b1010: begin r = x - y; sub = 1'b1; end
         default:          begin r = x - y - 65'(!c); sub = 1'b1; end
      endcase
      rr = r[63:0] & mask;
      cf = (add || sub) ? r[w] : 1'b0;
      v  = 1'b0;
      if (add) v = (x[msb] == y[msb]) && (rr[msb] != x[msb]);
      if (sub) v = (x[msb] != y[msb]) && (rr[msb] != x[msb]);
      return {rr[msb], (rr == 64'd0), cf, v, rr};
   endfunction

   // Parent's combinational 32-bit ALU
   always_comb alu_w = ref_op(alu_control, 1'b0, {32'd0, alu_src_a}, {32'd0, alu_src_b}, alu_carry_in);
   assign alu_result = alu_w[31:0];
   assign alu_flags  = alu_w[67:64];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one op from a negedge, check latency/result/flags, hold then consume.
   task automatic do_op(input logic [3:0] op, input logic wide, input logic sf,
                        input logic [63:0] a, input logic [63:0] b, input int hold);
      logic [67:0] m;
      int          k;
      logic        got;
      m = ref_op(op, wide, a, b, m_nzcv[1]);
      req_valid = 1'b1; req_op = op; req_wide = wide; req_setflags = sf;
      req_a = a; req_b = b;
      k = 0;
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      chk("accept", 64'(req_ready), 64'd1);
      if (!req_ready) begin req_valid = 1'b0; return; end
      @(posedge clk);
      k = 0; got = 1'b0;
      while (!got && k < 8) begin
         @(negedge clk); k++;
         if (k == 1) req_valid = 1'b0;
         tr_ctl[k] = alu_control;
         tr_cin[k] = alu_carry_in;
         got = rsp_valid;
      end
      chk("latency", 64'(k), wide ? 64'd3 : 64'd2);
      if (!got) return;
      last_res   = rsp_result;
      last_flags = rsp_flags;
      chk("result", rsp_result, m[63:0]);
      chk("rsp_flags", 64'(rsp_flags), 64'(m[67:64]));
      if (sf || op[3:2] == 2'b10) m_nzcv = m[67:64];
      chk("nzcv", 64'(nzcv), 64'(m_nzcv));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 64'(rsp_valid), 64'd1);
         chk("hold_result", rsp_result, m[63:0]);
         chk("hold_flags", 64'(rsp_flags), 64'(m[67:64]));
         chk("hold_req_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_op = 4'd0;
      req_wide = 1'b0; req_setflags = 1'b0; req_a = '0; req_b = '0;
      m_nzcv = 4'b0000;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_result", rsp_result, 64'd0);
      chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
      chk("rst_nzcv", 64'(nzcv), 64'd0);
      chk("rst_alu_ctl", 64'(alu_control), 64'd0);
      chk("rst_alu_a", 64'(alu_src_a), 64'd0);
      chk("rst_alu_cin", 64'(alu_carry_in), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 64'(req_ready), 64'd1);

      // Narrow ADD overflowing into the sign bit
      do_op(4'b0100, 1'b0, 1'b1, 64'h7FFF_FFFF, 64'd1, 0);
      chk("nadd_res", last_res, 64'h0000_0000_8000_0000);
      chk("nadd_flags", 64'(last_flags), 64'b1001);

      // Wide ADD: carry chains from LO into HI
      do_op(4'b0100, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0);
      chk("wadd_lo_ctl", 64'(tr_ctl[1]), 64'b0100);
      chk("wadd_lo_cin", 64'(tr_cin[1]), 64'd0);
      chk("wadd_hi_ctl", 64'(tr_ctl[2]), 64'b0101);
      chk("wadd_hi_cin", 64'(tr_cin[2]), 64'd1);
      chk("wadd_res", last_res, 64'h0000_0001_0000_0000);
      chk("wadd_flags", 64'(last_flags), 64'b0000);

      // Wide SUB: borrow from LO means HI carry-in of 0
      do_op(4'b0010, 1'b1, 1'b1, 64'h0000_0001_0000_0000, 64'd1, 0);
      chk("wsub_hi_ctl", 64'(tr_ctl[2]), 64'b0110);
      chk("wsub_hi_cin", 64'(tr_cin[2]), 64'd0);
      chk("wsub_res", last_res, 64'h0000_0000_FFFF_FFFF);
      chk("wsub_flags", 64'(last_flags), 64'b0000);

      // CMP commits without setflags; response held under back-pressure
      do_op(4'b1010, 1'b0, 1'b0, 64'd5, 64'd5, 5);
      chk("cmp_nzcv", 64'(nzcv), 64'b0100);

      // CMN sets C, then ADC consumes it in the LO pass
      do_op(4'b1011, 1'b0, 1'b0, 64'hFFFF_FFFF, 64'd1, 0);
      chk("cmn_nzcv", 64'(nzcv), 64'b0110);
      do_op(4'b0101, 1'b0, 1'b0, 64'd1, 64'd1, 0);
      chk("adc_lo_cin", 64'(tr_cin[1]), 64'd1);
      chk("adc_res", last_res, 64'd3);

      // Randomized ops
      for (int i = 0; i < 40; i++) begin
         logic [63:0] ra, rb;
         ra = {32'($urandom), 32'($urandom)};
         rb = {32'($urandom), 32'($urandom)};
         if ($urandom_range(0, 3) == 0) rb = ra;
         if ($urandom_range(0, 3) == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
         do_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 2));
      end

      // Reset during the HI pass abandons the op
      do_op(4'b1010, 1'b0, 1'b0, 64'd5, 64'd5, 0);
      req_valid = 1'b1; req_op = 4'b0100; req_wide = 1'b1; req_setflags = 1'b1;
      req_a = 64'hFFFF_FFFF_FFFF_FFFF; req_b = 64'd1;
      chk("rst_pre_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      chk("rst_hi_ctl", 64'(alu_control), 64'b0101);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_nzcv", 64'(nzcv), 64'd0);
      chk("midrst_req_ready", 64'(req_ready), 64'd0);
      chk("midrst_alu_ctl", 64'(alu_control), 64'd0);
      reset_n = 1'b1;
      m_nzcv = 4'b0000;
      @(negedge clk);
      chk("midrst_ready_after", 64'(req_ready), 64'd1);
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
      end

      // Back-to-back offer while the response is being consumed
      req_valid = 1'b1; req_op = 4'b0000; req_wide = 1'b0; req_setflags = 1'b0;
      req_a = 64'hF0; req_b = 64'h3C;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_rsp1_valid", 64'(rsp_valid), 64'd1);
      chk("b2b_rsp1_res", rsp_result, 64'h30);
      req_valid = 1'b1; req_op = 4'b0100; req_a = 64'd10; req_b = 64'd20;
      rsp_ready = 1'b1;
`ifdef ALU_OP_SEQUENCER_B2B_EN
      chk("b2b_ready_in_resp", 64'(req_ready), 64'd1);
      @(negedge clk); rsp_ready = 1'b0; req_valid = 1'b0;
      chk("b2b_lo_ctl", 64'(alu_control), 64'b0100);
      chk("b2b_lo_a", 64'(alu_src_a), 64'd10);
      chk("b2b_rsp_dropped", 64'(rsp_valid), 64'd0);
`else
      chk("bubble_ready_in_resp", 64'(req_ready), 64'd0);
      @(negedge clk); rsp_ready = 1'b0;
      chk("bubble_idle_ctl", 64'(alu_control), 64'd0);
      chk("bubble_idle_ready", 64'(req_ready), 64'd1);
      @(negedge clk); req_valid = 1'b0;
      chk("bubble_lo_ctl", 64'(alu_control), 64'b0100);
      chk("bubble_lo_a", 64'(alu_src_a), 64'd10);
`endif
      @(negedge clk);
      chk("b2b_rsp2_valid", 64'(rsp_valid), 64'd1);
      chk("b2b_rsp2_res", rsp_result, 64'd30);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
